// File: rtl/idu_sched_pkg.sv
// idu_sched_pkg: shared types and default latencies for the issue scheduler.
package idu_sched_pkg;
   localparam int DEF_XREGS = 32;
   localparam int DEF_MUL_LAT = 3;
   localparam int DEF_DIV_LAT = 16;
   typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_e;
   typedef struct packed {
      logic       valid;
      logic       rs1;
      logic       rs2;
      logic       rd;
      logic [4:0] rs1_addr;
      logic [4:0] rs2_addr;
      logic [4:0] rd_addr;
      logic       load;
      logic       mul;
      logic       div;
   } sched_in_t;
endpackage

// File: rtl/idu_sched_if.sv
// idu_sched_if: decode/execute-side signal bundle of the issue scheduler.
interface idu_sched_if #(parameter int XREGS = 32);
   logic             dec_valid, dec_rs1, dec_rs2, dec_rd;
   logic [4:0]       dec_rs1_addr, dec_rs2_addr, dec_rd_addr;
   logic             dec_load, dec_mul, dec_div;
   logic             exu_flush, ext_stall, lsu_wb_valid;
   logic [4:0]       lsu_wb_rd;
   logic             pipe_stall, pipe_flush, issue_valid;
   logic             div_start, div_busy, mul_done, div_done;
   logic [4:0]       mul_done_rd, div_done_rd;
   logic [XREGS-1:0] sb_pending;
   modport master (
      output dec_valid, dec_rs1, dec_rs2, dec_rd, dec_rs1_addr, dec_rs2_addr, dec_rd_addr,
             dec_load, dec_mul, dec_div, exu_flush, ext_stall, lsu_wb_valid, lsu_wb_rd,
      input  pipe_stall, pipe_flush, issue_valid, div_start, div_busy, mul_done, mul_done_rd,
             div_done, div_done_rd, sb_pending
   );
   modport slave (
      input  dec_valid, dec_rs1, dec_rs2, dec_rd, dec_rs1_addr, dec_rs2_addr, dec_rd_addr,
             dec_load, dec_mul, dec_div, exu_flush, ext_stall, lsu_wb_valid, lsu_wb_rd,
      output pipe_stall, pipe_flush, issue_valid, div_start, div_busy, mul_done, mul_done_rd,
             div_done, div_done_rd, sb_pending
   );
endinterface

// File: rtl/idu_sched_div_seq.sv
// div_seq: divider occupancy FSM; done pulses DIV_LAT cycles after the start cycle.
module div_seq
   import idu_sched_pkg::*;
#(
   parameter int DIV_LAT = DEF_DIV_LAT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [4:0] rd,
   output logic       div_start,
   output logic       div_busy,
   output logic       div_done,
   output logic [4:0] div_done_rd
);
   localparam int CW = $clog2(DIV_LAT);
   div_state_e st, st_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [4:0] rd_q, rd_n;
   always_ff @(posedge clk) begin
      if (rst) begin
         st <= IDLE;
         cnt <= '0;
         rd_q <= '0;
      end else begin
         st <= st_n;
         cnt <= cnt_n;
         rd_q <= rd_n;
      end
   end
   // Counter reaches 0 on entry to DONE, so DONE lands exactly DIV_LAT cycles after start.
   always_comb begin
      st_n = st;
      cnt_n = cnt;
      rd_n = rd_q;
      div_start = start & (st == IDLE);
      case (st)
         IDLE: begin
            st_n = div_start ? BUSY : IDLE;
            cnt_n = div_start ? CW'(DIV_LAT - 1) : cnt;
            rd_n = div_start ? rd : rd_q;
         end
         BUSY: begin
            cnt_n = cnt - CW'(1);
            st_n = (cnt == CW'(1)) ? DONE : BUSY;
         end
         default: st_n = IDLE;
      endcase
   end
   assign div_busy = st != IDLE;
   assign div_done = st == DONE;
   assign div_done_rd = rd_q;
endmodule

// File: rtl/idu_sched.sv
// idu_sched: issue scheduler with long-latency scoreboard, multiplier pipe and divider sequencing.
module idu_sched
   import idu_sched_pkg::*;
#(
   parameter int XREGS = DEF_XREGS,
   parameter int MUL_LAT = DEF_MUL_LAT,
   parameter int DIV_LAT = DEF_DIV_LAT
) (
   input logic clk,
   input logic rst,
   idu_sched_if.slave bus
);
   sched_in_t d;
   logic hazard, issue, div_busy, div_done;
   logic [4:0] div_done_rd;
   logic [XREGS-1:0] sb, set_m, clr_m;
   logic [MUL_LAT-1:0] mv;
   logic [MUL_LAT-1:0][4:0] mrd;
   assign d = '{valid: bus.dec_valid, rs1: bus.dec_rs1, rs2: bus.dec_rs2, rd: bus.dec_rd,
                rs1_addr: bus.dec_rs1_addr, rs2_addr: bus.dec_rs2_addr, rd_addr: bus.dec_rd_addr,
                load: bus.dec_load, mul: bus.dec_mul, div: bus.dec_div};
   // Hazards see only registered scoreboard state: a dependent issues the cycle after the clear.
   always_comb begin
      hazard = (d.rs1 & |d.rs1_addr & sb[d.rs1_addr]) | (d.rs2 & |d.rs2_addr & sb[d.rs2_addr])
             | (d.rd & |d.rd_addr & sb[d.rd_addr]) | (d.div & div_busy);
      issue = d.valid & ~bus.exu_flush & ~hazard & ~bus.ext_stall;
      set_m = '0;
      clr_m = '0;
      set_m[d.rd_addr] = issue & d.rd & |d.rd_addr & (d.load | d.mul | d.div);
      clr_m[bus.lsu_wb_rd] = bus.lsu_wb_valid;
      clr_m[mrd[MUL_LAT-1]] = clr_m[mrd[MUL_LAT-1]] | mv[MUL_LAT-1];
      clr_m[div_done_rd] = clr_m[div_done_rd] | div_done;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         sb <= '0;
         mv <= '0;
         mrd <= '0;
      end else begin
         sb <= (sb & ~clr_m) | set_m;
         mv[0] <= issue & d.mul;
         mrd[0] <= d.rd_addr;
         for (int i = 1; i < MUL_LAT; i++) begin
            mv[i] <= mv[i-1];
            mrd[i] <= mrd[i-1];
         end
      end
   end
   div_seq #(.DIV_LAT(DIV_LAT)) u_div (
      .clk(clk),
      .rst(rst),
      .start(issue & d.div),
      .rd(d.rd_addr),
      .div_start(bus.div_start),
      .div_busy(div_busy),
      .div_done(div_done),
      .div_done_rd(div_done_rd)
   );
   assign bus.pipe_flush = bus.exu_flush;
   assign bus.pipe_stall = d.valid & ~bus.exu_flush & (hazard | bus.ext_stall);
   assign bus.issue_valid = issue;
   assign bus.div_busy = div_busy;
   assign bus.div_done = div_done;
   assign bus.div_done_rd = div_done_rd;
   assign bus.mul_done = mv[MUL_LAT-1];
   assign bus.mul_done_rd = mrd[MUL_LAT-1];
   assign bus.sb_pending = sb;
endmodule

// File: tb/tb_idu_sched.sv
// tb_idu_sched: table vectors, directed corner sequences and a randomized run against a timeline model.
module tb_idu_sched;
   localparam int MUL_LAT = 3;
   localparam int DIV_LAT = 16;
   logic clk = 0;
   logic rst;
   int checks = 0;
   int failures = 0;
   idu_sched_if #(.XREGS(32)) bus ();
   idu_sched #(.XREGS(32), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
   always #5 clk = ~clk;

   typedef struct {
      int v, r1, a1, r2, a2, rd, ad, dv, fl, xs, e_stall, e_issue;
   } vec_t;
   vec_t tbl[13];
   typedef struct {
      int due;
      logic [4:0] rd;
   } mop_t;

   task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", n, a, e, $time);
      end
   endtask

   function automatic logic [63:0] all_outs();
      return {15'd0, bus.pipe_stall, bus.pipe_flush, bus.issue_valid, bus.div_start, bus.div_busy,
              bus.div_done, bus.div_done_rd, bus.mul_done, bus.mul_done_rd, bus.sb_pending};
   endfunction

   task automatic set_dec(input logic v, r1, input logic [4:0] a1, input logic r2, input logic [4:0] a2,
                          input logic rd, input logic [4:0] ad, input logic ld, ml, dv);
      bus.dec_valid = v; bus.dec_rs1 = r1; bus.dec_rs1_addr = a1; bus.dec_rs2 = r2; bus.dec_rs2_addr = a2;
      bus.dec_rd = rd; bus.dec_rd_addr = ad; bus.dec_load = ld; bus.dec_mul = ml; bus.dec_div = dv;
   endtask

   task automatic idle_in();
      set_dec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      bus.exu_flush = 0; bus.ext_stall = 0; bus.lsu_wb_valid = 0; bus.lsu_wb_rd = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      idle_in();
      rst = 1;
      @(negedge clk);
      rst = 0;
      #1 chk("reset_outs", all_outs(), 64'd0);
   endtask

   // Randomized run: model keeps pending bits, a list of multiply due-times and the divide start time.
   task automatic random_run(input int n);
      bit pend[32];
      mop_t mq[$];
      int dt0 = -1;
      logic [4:0] drd = 0;
      logic [31:0] esb;
      logic r, v, r1, r2, rd, ld, ml, dv, fl, xs, lw, haz, iss, mdone, ddone, dbusy;
      logic [4:0] a1, a2, ad, lwr, mrd;
      int cls;
      for (int i = 0; i < 32; i++) pend[i] = 0;
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         r = ($urandom % 256) == 0;
         v = ($urandom % 5) != 0;
         cls = $urandom % 4;
         ld = cls == 1; ml = cls == 2; dv = cls == 3;
         r1 = $urandom % 2; r2 = $urandom % 2; rd = ($urandom % 4) != 0;
         a1 = 5'($urandom % 8); a2 = 5'($urandom % 8); ad = 5'($urandom % 8);
         fl = ($urandom % 10) == 0; xs = ($urandom % 10) == 0;
         lw = ($urandom % 3) == 0; lwr = 5'($urandom % 8);
         rst = r;
         set_dec(v, r1, a1, r2, a2, rd, ad, ld, ml, dv);
         bus.exu_flush = fl; bus.ext_stall = xs; bus.lsu_wb_valid = lw; bus.lsu_wb_rd = lwr;
         mdone = mq.size() > 0 && mq[0].due == c;
         mrd = mdone ? mq[0].rd : 5'd0;
         ddone = dt0 >= 0 && c == dt0 + DIV_LAT;
         dbusy = dt0 >= 0 && c > dt0 && c <= dt0 + DIV_LAT;
         haz = (r1 && a1 != 0 && pend[a1]) || (r2 && a2 != 0 && pend[a2]) || (rd && ad != 0 && pend[ad]) || (dv && dbusy);
         iss = v && !fl && !haz && !xs;
         for (int i = 0; i < 32; i++) esb[i] = pend[i];
         #1;
         chk("rand_ctl", {bus.pipe_stall, bus.pipe_flush, bus.issue_valid, bus.div_start, bus.div_busy, bus.div_done,
                          bus.div_done ? bus.div_done_rd : 5'd0, bus.mul_done, bus.mul_done ? bus.mul_done_rd : 5'd0},
             {v && !fl && (haz || xs), fl, iss, iss && dv, dbusy, ddone, ddone ? drd : 5'd0, mdone, mrd});
         chk("rand_sb", bus.sb_pending, esb);
         if (r) begin
            for (int i = 0; i < 32; i++) pend[i] = 0;
            mq.delete();
            dt0 = -1;
         end else begin
            if (mdone) begin pend[mrd] = 0; void'(mq.pop_front()); end
            if (lw) pend[lwr] = 0;
            if (ddone) begin pend[drd] = 0; dt0 = -1; end
            if (iss && rd && ad != 0 && (ld || ml || dv)) pend[ad] = 1;
            if (iss && ml) mq.push_back('{c + MUL_LAT, ad});
            if (iss && dv) begin dt0 = c; drd = ad; end
         end
      end
      @(negedge clk);
      rst = 0;
      idle_in();
   endtask

   initial begin
      tbl[0]  = '{1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 1, 0};
      tbl[1]  = '{1, 1, 0, 1, 1, 1, 2, 0, 0, 0, 0, 1};
      tbl[2]  = '{1, 0, 0, 1, 4, 0, 0, 0, 0, 0, 1, 0};
      tbl[3]  = '{1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 1, 0};
      tbl[4]  = '{1, 0, 0, 0, 0, 1, 10, 0, 0, 0, 1, 0};
      tbl[5]  = '{1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0};
      tbl[6]  = '{1, 1, 5, 1, 6, 1, 7, 0, 0, 0, 0, 1};
      tbl[7]  = '{1, 0, 3, 0, 4, 0, 10, 0, 0, 0, 0, 1};
      tbl[8]  = '{1, 1, 3, 0, 0, 0, 0, 0, 1, 0, 0, 0};
      tbl[9]  = '{0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      tbl[10] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0};
      tbl[11] = '{1, 1, 10, 0, 0, 0, 0, 0, 1, 1, 0, 0};
      tbl[12] = '{1, 1, 0, 1, 0, 1, 0, 0, 0, 1, 1, 0};
      rst = 1;
      idle_in();
      repeat (2) @(negedge clk);
      do_reset();

      // load x5, dependent add stalls until the writeback edge has passed
      @(negedge clk); set_dec(1, 0, 0, 0, 0, 1, 5, 1, 0, 0);
      #1 chk("t1_load_issue", bus.issue_valid, 1);
      for (int t = 1; t <= 4; t++) begin
         @(negedge clk); set_dec(1, 1, 5, 1, 1, 1, 6, 0, 0, 0);
         bus.lsu_wb_valid = t == 4; bus.lsu_wb_rd = 5;
         #1 chk("t1_stall", {bus.pipe_stall, bus.issue_valid, bus.sb_pending[5]}, 3'b101);
      end
      @(negedge clk); bus.lsu_wb_valid = 0;
      #1 chk("t1_issue", {bus.pipe_stall, bus.issue_valid, bus.sb_pending[5]}, 3'b010);

      // two back-to-back divides
      do_reset();
      @(negedge clk); set_dec(1, 0, 0, 0, 0, 1, 11, 0, 0, 1);
      #1 chk("t2_start0", {bus.issue_valid, bus.div_start, bus.div_busy}, 3'b110);
      for (int t = 1; t <= 16; t++) begin
         @(negedge clk); set_dec(1, 0, 0, 0, 0, 1, 12, 0, 0, 1);
         #1 chk("t2_wait", {bus.pipe_stall, bus.issue_valid, bus.div_start, bus.div_busy, bus.div_done},
                {4'b1001, 1'(t == 16)});
      end
      chk("t2_done_rd", bus.div_done_rd, 11);
      @(negedge clk);
      #1 chk("t2_start1", {bus.issue_valid, bus.div_start, bus.div_busy, bus.div_done}, 4'b1100);

      // pipelined multiplies
      do_reset();
      @(negedge clk); set_dec(1, 0, 0, 0, 0, 1, 7, 0, 1, 0);
      #1 chk("t3_mul7", {bus.issue_valid, bus.pipe_stall}, 2'b10);
      @(negedge clk); set_dec(1, 0, 0, 0, 0, 1, 8, 0, 1, 0);
      #1 chk("t3_mul8", {bus.issue_valid, bus.pipe_stall}, 2'b10);
      @(negedge clk); idle_in();
      @(negedge clk);
      #1 chk("t3_done7", {bus.mul_done, bus.mul_done_rd}, {1'b1, 5'd7});
      @(negedge clk);
      #1 chk("t3_done8", {bus.mul_done, bus.mul_done_rd, bus.sb_pending}, {1'b1, 5'd8, 32'h100});
      @(negedge clk);
      #1 chk("t3_idle", {bus.mul_done, bus.sb_pending}, 33'd0);

      // hazard and flush together
      do_reset();
      @(negedge clk); set_dec(1, 0, 0, 0, 0, 1, 5, 1, 0, 0);
      @(negedge clk); set_dec(1, 1, 5, 0, 0, 1, 6, 0, 0, 0); bus.exu_flush = 1;
      #1 chk("t4_flush_haz", {bus.pipe_flush, bus.pipe_stall, bus.issue_valid, bus.sb_pending}, {3'b100, 32'h20});
      @(negedge clk); set_dec(1, 0, 0, 0, 0, 1, 9, 1, 0, 0);
      #1 chk("t4_flush_load", {bus.pipe_flush, bus.pipe_stall, bus.issue_valid}, 3'b100);
      @(negedge clk); idle_in();
      #1 chk("t4_sb", bus.sb_pending, 32'h20);

      // set wins over same-cycle clears; x0 destination never tracked
      do_reset();
      @(negedge clk); set_dec(1, 0, 0, 0, 0, 0, 9, 0, 1, 0);
      @(negedge clk); idle_in();
      @(negedge clk);
      @(negedge clk); set_dec(1, 0, 0, 0, 0, 1, 9, 1, 0, 0); bus.lsu_wb_valid = 1; bus.lsu_wb_rd = 9;
      #1 chk("t5_collide", {bus.mul_done, bus.mul_done_rd, bus.issue_valid}, {1'b1, 5'd9, 1'b1});
      @(negedge clk); set_dec(1, 0, 0, 0, 0, 1, 0, 1, 0, 0);
      #1 chk("t5_set_wins", {bus.issue_valid, bus.sb_pending}, {1'b1, 32'h200});
      @(negedge clk); idle_in();
      #1 chk("t5_x0", bus.sb_pending, 32'd0);

      // reset in the middle of a divide
      do_reset();
      @(negedge clk); set_dec(1, 0, 0, 0, 0, 1, 13, 0, 0, 1);
      for (int t = 1; t <= 4; t++) begin @(negedge clk); idle_in(); end
      #1 chk("t6_busy", {bus.div_busy, bus.sb_pending[13]}, 2'b11);
      @(negedge clk); rst = 1;
      @(negedge clk); rst = 0;
      #1 chk("t6_reset_outs", all_outs(), 64'd0);
      for (int t = 0; t < 20; t++) begin
         @(negedge clk);
         #1 chk("t6_no_done", {bus.div_done, bus.div_busy}, 2'b00);
      end

      // table vectors against loads x3, x4 and a busy divide to x10
      do_reset();
      @(negedge clk); set_dec(1, 0, 0, 0, 0, 1, 3, 1, 0, 0);
      @(negedge clk); set_dec(1, 0, 0, 0, 0, 1, 4, 1, 0, 0);
      @(negedge clk); set_dec(1, 0, 0, 0, 0, 1, 10, 0, 0, 1);
      #1 chk("tbl_setup_div", bus.div_start, 1);
      for (int i = 0; i < 13; i++) begin
         @(negedge clk);
         set_dec(1'(tbl[i].v), 1'(tbl[i].r1), 5'(tbl[i].a1), 1'(tbl[i].r2), 5'(tbl[i].a2),
                 1'(tbl[i].rd), 5'(tbl[i].ad), 0, 0, 1'(tbl[i].dv));
         bus.exu_flush = 1'(tbl[i].fl); bus.ext_stall = 1'(tbl[i].xs);
         #1 chk($sformatf("tbl%0d", i), {bus.pipe_stall, bus.issue_valid, bus.pipe_flush},
                {1'(tbl[i].e_stall), 1'(tbl[i].e_issue), 1'(tbl[i].fl)});
      end

      do_reset();
      random_run(3000);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
